vga_text_renderer: RTL

Character-cell pixel source that sits directly downstream of the VGA timing generator. It consumes the generator's pixel/line counters, active flag and syncs, fetches character codes and attributes from an external character RAM and glyph rows from an external font ROM, and produces 1-bit-per-channel RGB. The syncs are delayed through the same pipeline so RGB, HS and VS stay aligned at the pins. The display is 52×30 cells of 8×16 pixels, covering 416×480 of the visible area.

---
 rtl/vga_text_renderer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_text_renderer.sv
// vga_text_renderer
//   Character-cell pixel source placed after the VGA timing generator. Each
//   input sample (pixel/line counters, active flag, syncs) walks a 5-stage
//   pipeline: character RAM fetch, font ROM fetch, bit select, colour mux and
//   output register. The syncs are delayed by the same 5 cycles so RGB and
//   HS/VS stay aligned. The character area is COLS x ROWS cells of 8x16 px.
//
//   Optional feature: define VGA_TEXT_CURSOR_EN to enable a blinking underline
//   cursor on glyph lines 14-15 of the cell at (CURSOR_COL, CURSOR_ROW).
//
// Ports
//   CLK, RST             pixel clock, asynchronous active-high reset
//   PIX_X, LINE_Y        pixel/line counters from the timing block
//   ACTIVE               visible-area flag
//   HS_IN, VS_IN         active-low syncs from the timing block
//   CHAR_ADDR/CHAR_DATA  character RAM port (data one cycle after address)
//   FONT_ADDR/FONT_DATA  font ROM port (data one cycle after address)
//   CURSOR_COL/ROW       cursor cell position (used only with the cursor build)
//   R, G, B              1-bit pixel colour
//   HS_OUT, VS_OUT       syncs delayed to match RGB

module vga_text_renderer #(
    parameter int unsigned COLS         = 52,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] PIX_X,
    input  logic [15:0] LINE_Y,
    input  logic        ACTIVE,
    input  logic        HS_IN,
    input  logic        VS_IN,
    output logic [10:0] CHAR_ADDR,
    input  logic [15:0] CHAR_DATA,
    output logic [10:0] FONT_ADDR,
    input  logic [7:0]  FONT_DATA,
    input  logic [5:0]  CURSOR_COL,
    input  logic [4:0]  CURSOR_ROW,
    output logic        R,
    output logic        G,
    output logic        B,
    output logic        HS_OUT,
    output logic        VS_OUT
);

    localparam logic [15:0] XMax = 16'(COLS * 8);
    localparam logic [15:0] YMax = 16'(ROWS * 16);

    // Cell decode of the incoming sample
    logic [5:0]  col;
    logic [4:0]  row;
    logic [3:0]  glyph_line;
    logic [2:0]  bit_idx;
    logic        in_area;
    logic [10:0] row11;
    logic [10:0] row_base;
    logic        cursor_hit;

    // Side-information shift registers; index k holds the sample k+1 cycles old
    logic [3:0]      area_q, area_d;
    logic [3:0][2:0] bit_q, bit_d;
    logic [1:0][3:0] gl_q, gl_d;
    logic [3:0]      hit_q, hit_d;
    logic [4:0]      hs_q, hs_d;
    logic [4:0]      vs_q, vs_d;

    logic [10:0] char_addr_q, char_addr_d;
    logic [10:0] font_addr_q, font_addr_d;
    logic [2:0]  fg_q, fg_d, bg_q, bg_d;
    logic [2:0]  fg4_q, bg4_q;
    logic [2:0]  rgb_q, rgb_d;
    logic        pix_on;

    logic unused_char_bits;
    assign unused_char_bits = ^{CHAR_DATA[15:14], CHAR_DATA[7]};

    always_comb begin
        col        = PIX_X[8:3];
        row        = LINE_Y[8:4];
        glyph_line = LINE_Y[3:0];
        bit_idx    = PIX_X[2:0];
        in_area    = ACTIVE && (PIX_X < XMax) && (LINE_Y < YMax);
        row11      = {6'b0, row};
        // row*52 = row*32 + row*16 + row*4
        if (COLS == 52) begin
            row_base = (row11 << 5) + (row11 << 4) + (row11 << 2);
        end else begin
            row_base = 11'(row11 * COLS);
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    localparam logic [5:0] BlinkLast = 6'(2 * BLINK_FRAMES - 1);
    localparam logic [5:0] BlinkOn   = 6'(BLINK_FRAMES);

    logic [5:0] frame_q, frame_d;
    logic       vs_prev_q;

    always_comb begin
        frame_d = frame_q;
        if (vs_prev_q && !VS_IN) begin
            frame_d = (frame_q == BlinkLast) ? 6'd0 : frame_q + 6'd1;
        end
        cursor_hit = (frame_q < BlinkOn) && (col == CURSOR_COL) && (row == CURSOR_ROW) &&
                     (glyph_line[3:1] == 3'b111);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            frame_q   <= 6'd0;
            vs_prev_q <= 1'b1;
        end else begin
            frame_q   <= frame_d;
            vs_prev_q <= VS_IN;
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{CURSOR_COL, CURSOR_ROW, 6'(BLINK_FRAMES)};
    assign cursor_hit    = 1'b0;
`endif

    always_comb begin
        area_d = {area_q[2:0], in_area};
        bit_d  = {bit_q[2:0], bit_idx};
        gl_d   = {gl_q[0], glyph_line};
        hit_d  = {hit_q[2:0], cursor_hit};
        hs_d   = {hs_q[3:0], HS_IN};
        vs_d   = {vs_q[3:0], VS_IN};

        // Addresses hold outside the character area
        char_addr_d = in_area ? row_base + {5'b0, col} : char_addr_q;
        font_addr_d = area_q[1] ? {CHAR_DATA[6:0], gl_q[1]} : font_addr_q;
        fg_d        = CHAR_DATA[10:8];
        bg_d        = CHAR_DATA[13:11];

        pix_on = FONT_DATA[3'd7 - bit_q[3]] | hit_q[3];
        rgb_d  = area_q[3] ? (pix_on ? fg4_q : bg4_q) : 3'b000;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            area_q      <= '0;
            bit_q       <= '0;
            gl_q        <= '0;
            hit_q       <= '0;
            hs_q        <= '1;
            vs_q        <= '1;
            char_addr_q <= '0;
            font_addr_q <= '0;
            fg_q        <= '0;
            bg_q        <= '0;
            fg4_q       <= '0;
            bg4_q       <= '0;
            rgb_q       <= '0;
        end else begin
            area_q      <= area_d;
            bit_q       <= bit_d;
            gl_q        <= gl_d;
            hit_q       <= hit_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            char_addr_q <= char_addr_d;
            font_addr_q <= font_addr_d;
            fg_q        <= fg_d;
            bg_q        <= bg_d;
            fg4_q       <= fg_q;
            bg4_q       <= bg_q;
            rgb_q       <= rgb_d;
        end
    end

    assign CHAR_ADDR = char_addr_q;
    assign FONT_ADDR = font_addr_q;
    assign R         = rgb_q[2];
    assign G         = rgb_q[1];
    assign B         = rgb_q[0];
    assign HS_OUT    = hs_q[4];
    assign VS_OUT    = vs_q[4];

endmodule
